wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Parametrised washing-machine program sequencer: successor to the fixed single-wash controller. Runs one soap wash followed by a configurable number of rinse passes and a final spin, all timed by an internal down-counter rather than external timeout inputs. Adds pause, a door-open fault and a status readout. Sits between the front-panel logic and the valve/motor drivers.

## Interface
- CNT_W, 16: timer width in bits; every *_TICKS value must fit in CNT_W and be ≥1.
- RINSE_CNT, 2: rinse passes after the soap wash (0..15); 0 skips straight to spin.
- DET_TICKS, 8: cycles soap_valve is open.
- WASH_TICKS, 1000: agitate cycles, soap wash.
- RINSE_TICKS, 500: agitate cycles, each rinse.
- SPIN_TICKS, 800: spin cycles.
- FILL_TIMEOUT, 4000: watchdog limit for FILL/DRAIN (only with WASH_WATCHDOG_EN).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level; request program start / acknowledge completion.
- door_closed  in  1  door sensor.
- pause  in  1  level; freezes program.
- filled  in  1  level sensor, drum full.
- drained  in  1  level sensor, drum empty.
- door_lock, motor_on, spin_on, fill_valve, drain_valve, soap_valve  out  1 each  actuator drives.
- done  out  1  program complete.
- fault  out  1  sticky fault.
- state  out  4  current state encoding.
- rinse_idx  out  4  rinse passes completed.

## Operation
- States (encoding): IDLE 0, FILL 1, DETERGENT 2, AGITATE 3, DRAIN 4, SPIN 5, DONE 6, FAULT 7; other codes → IDLE next cycle.
- IDLE: all outputs 0. start & door_closed → FILL, rinse_idx=0, phase=WASH.
- FILL: fill_valve=1. filled → DETERGENT if phase=WASH, else AGITATE.
- DETERGENT: soap_valve=1 for DET_TICKS cycles → AGITATE.
- AGITATE: motor_on=1 for WASH_TICKS (phase WASH) or RINSE_TICKS (phase RINSE) cycles → DRAIN.
- DRAIN: drain_valve=1. drained → if phase=WASH: phase=RINSE, then FILL if RINSE_CNT>0 else SPIN; if phase=RINSE: rinse_idx+=1, then FILL if new rinse_idx<RINSE_CNT else SPIN.
- SPIN: spin_on=1, drain_valve=1 for SPIN_TICKS cycles → DONE.
- DONE: done=1, door_lock=0, all else 0. start==0 → IDLE.
- FAULT: door_lock=0, fault=1, all actuators 0; exits only on rst.
- door_lock=1 in FILL, DETERGENT, AGITATE, DRAIN, SPIN.
- Door fault: door_closed==0 in any locked state → FAULT (priority over all other transitions, including pause).
- Pause: in locked states, pause==1 forces motor_on, spin_on, fill_valve, drain_valve, soap_valve to 0; state, timer, rinse_idx frozen; door_lock stays 1. No effect in IDLE/DONE/FAULT.
- filled and drained both 1 in FILL/DRAIN: only the sensor for the current state is examined.
- start ignored outside IDLE/DONE.

## Timing
- All outputs registered; updated on the same edge as state; combinational paths from inputs to outputs forbidden.
- Reset: state=IDLE, timer=0, rinse_idx=0, phase=WASH, every output 0. rst mid-program returns to IDLE next edge; fault cleared.
- Timer loads TICKS-1 on state entry, decrements each unpaused cycle; exit when timer==0 and unpaused. Timed state occupies exactly TICKS unpaused cycles.
- Sensor-driven exit (filled/drained): next state visible one cycle after sensor sampled high.
- IDLE→FILL: fill_valve high the cycle after start & door_closed sampled.

## Configuration
- WASH_WATCHDOG_EN defined: timer also runs in FILL and DRAIN, loaded FILL_TIMEOUT-1; reaching 0 without the sensor → FAULT. Paused cycles do not count.
- Undefined: FILL/DRAIN wait on sensors indefinitely; FILL_TIMEOUT unused; timer idle in those states.

## Test plan
- Params DET=2, WASH=4, RINSE=3, SPIN=5, RINSE_CNT=1; start with door closed, filled/drained returned 2 cycles after valve opens -> state sequence 1,2,3,4,1,3,4,5,6; motor_on high exactly 4 then 3 cycles; spin_on 5 cycles; rinse_idx ends at 1; done held until start drops, then state=0.
- RINSE_CNT=0 -> after wash DRAIN goes directly to SPIN; rinse_idx stays 0.
- pause high for 3 cycles mid-AGITATE -> motor_on 0 during pause, door_lock 1, total AGITATE occupancy = WASH_TICKS+3 cycles.
- door_closed dropped during SPIN -> next cycle state=7, fault=1, door_lock=0, all actuators 0; start ignored; rst -> state 0, fault 0.
- WASH_WATCHDOG_EN, FILL_TIMEOUT=6, filled never asserted -> FAULT after exactly 6 FILL cycles; without macro, state remains FILL after 100 cycles.
- rst pulsed during DETERGENT -> next cycle all outputs 0, state 0; start with door open -> stays IDLE.

Source files
------------

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: soap wash, RINSE_CNT rinses, final spin, internally timed.
// Define WASH_WATCHDOG_EN to fault when FILL or DRAIN waits longer than FILL_TIMEOUT cycles.
module wash_sequencer #(
  parameter int CNT_W        = 16,
  parameter int RINSE_CNT    = 2,
  parameter int DET_TICKS    = 8,
  parameter int WASH_TICKS   = 1000,
  parameter int RINSE_TICKS  = 500,
  parameter int SPIN_TICKS   = 800,
  parameter int FILL_TIMEOUT = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       door_closed,
  input  logic       pause,
  input  logic       filled,
  input  logic       drained,
  output logic       door_lock,
  output logic       motor_on,
  output logic       spin_on,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       soap_valve,
  output logic       done,
  output logic       fault,
  output logic [3:0] state,
  output logic [3:0] rinse_idx
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FILL      = 4'd1,
    S_DETERGENT = 4'd2,
    S_AGITATE   = 4'd3,
    S_DRAIN     = 4'd4,
    S_SPIN      = 4'd5,
    S_DONE      = 4'd6,
    S_FAULT     = 4'd7
  } state_e;

  localparam logic [CNT_W-1:0] DET_LOAD   = CNT_W'(DET_TICKS - 1);
  localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_TICKS - 1);
  localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_TICKS - 1);
  localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_TICKS - 1);
`ifdef WASH_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(FILL_TIMEOUT - 1);
`else
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(FILL_TIMEOUT - FILL_TIMEOUT);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       rinse_idx_q, rinse_idx_d;
  logic             phase_q, phase_d;  // 0 = soap wash, 1 = rinse
  logic             door_lock_q, door_lock_d;
  logic             motor_on_q, motor_on_d;
  logic             spin_on_q, spin_on_d;
  logic             fill_valve_q, fill_valve_d;
  logic             drain_valve_q, drain_valve_d;
  logic             soap_valve_q, soap_valve_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  logic       locked;
  logic       paused;
  logic [3:0] rinse_next;

  assign locked     = (state_q inside {S_FILL, S_DETERGENT, S_AGITATE, S_DRAIN, S_SPIN});
  assign paused     = pause & locked;
  assign rinse_next = rinse_idx_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      rinse_idx_q   <= '0;
      phase_q       <= 1'b0;
      door_lock_q   <= 1'b0;
      motor_on_q    <= 1'b0;
      spin_on_q     <= 1'b0;
      fill_valve_q  <= 1'b0;
      drain_valve_q <= 1'b0;
      soap_valve_q  <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rinse_idx_q   <= rinse_idx_d;
      phase_q       <= phase_d;
      door_lock_q   <= door_lock_d;
      motor_on_q    <= motor_on_d;
      spin_on_q     <= spin_on_d;
      fill_valve_q  <= fill_valve_d;
      drain_valve_q <= drain_valve_d;
      soap_valve_q  <= soap_valve_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rinse_idx_d = rinse_idx_q;
    phase_d     = phase_q;
    // An open door while locked beats everything, pause included.
    if (locked && !door_closed) begin
      state_d = S_FAULT;
    end else if (!paused) begin
      case (state_q)
        S_IDLE: begin
          if (start && door_closed) begin
            state_d     = S_FILL;
            rinse_idx_d = '0;
            phase_d     = 1'b0;
          end
        end
        S_FILL: begin
          if (filled) state_d = phase_q ? S_AGITATE : S_DETERGENT;
`ifdef WASH_WATCHDOG_EN
          else if (timer_q == '0) state_d = S_FAULT;
          else timer_d = timer_q - CNT_W'(1);
`endif
        end
        S_DETERGENT, S_AGITATE, S_SPIN: begin
          if (timer_q == '0) begin
            if (state_q == S_DETERGENT)    state_d = S_AGITATE;
            else if (state_q == S_AGITATE) state_d = S_DRAIN;
            else                           state_d = S_DONE;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (drained) begin
            if (!phase_q) begin
              phase_d = 1'b1;
              state_d = (RINSE_CNT > 0) ? S_FILL : S_SPIN;
            end else begin
              rinse_idx_d = rinse_next;
              state_d     = (rinse_next < 4'(RINSE_CNT)) ? S_FILL : S_SPIN;
            end
          end
`ifdef WASH_WATCHDOG_EN
          else if (timer_q == '0) state_d = S_FAULT;
          else timer_d = timer_q - CNT_W'(1);
`endif
        end
        S_DONE:  if (!start) state_d = S_IDLE;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
    // Every state entry reloads the timer with that state's duration.
    if (state_d != state_q) begin
      case (state_d)
        S_DETERGENT:     timer_d = DET_LOAD;
        S_AGITATE:       timer_d = phase_d ? RINSE_LOAD : WASH_LOAD;
        S_SPIN:          timer_d = SPIN_LOAD;
        S_FILL, S_DRAIN: timer_d = WAIT_LOAD;
        default:         timer_d = '0;
      endcase
    end
  end

  always_comb begin
    door_lock_d   = (state_d inside {S_FILL, S_DETERGENT, S_AGITATE, S_DRAIN, S_SPIN});
    motor_on_d    = (state_d == S_AGITATE) && !paused;
    spin_on_d     = (state_d == S_SPIN) && !paused;
    fill_valve_d  = (state_d == S_FILL) && !paused;
    drain_valve_d = (state_d == S_DRAIN || state_d == S_SPIN) && !paused;
    soap_valve_d  = (state_d == S_DETERGENT) && !paused;
    done_d        = (state_d == S_DONE);
    fault_d       = (state_d == S_FAULT);
  end

  assign door_lock   = door_lock_q;
  assign motor_on    = motor_on_q;
  assign spin_on     = spin_on_q;
  assign fill_valve  = fill_valve_q;
  assign drain_valve = drain_valve_q;
  assign soap_valve  = soap_valve_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign state       = state_q;
  assign rinse_idx   = rinse_idx_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: two instances (one rinse / no rinse) share stimulus and are
// compared every cycle against a cycle-count model, plus a directed vector table and corner sequences.
module tb_wash_sequencer;

  localparam int DET = 2, WASH = 4, RINSE = 3, SPIN = 5, FT = 6;
`ifdef WASH_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, door_closed, pause, filled, drained;

  logic lock_a, motor_a, spin_a, fill_a, drain_a, soap_a, done_a, fault_a;
  logic [3:0] state_a, ridx_a;
  logic lock_b, motor_b, spin_b, fill_b, drain_b, soap_b, done_b, fault_b;
  logic [3:0] state_b, ridx_b;
  logic [15:0] obs_a, obs_b;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_st[2];
  int          m_el[2];
  int          m_idx[2];
  bit          m_rinse[2];
  logic [15:0] m_out[2];

  typedef struct {
    logic [4:0] in;     // {start, door_closed, pause, filled, drained}
    logic [3:0] st_a;
    logic [3:0] ri_a;
    logic [6:0] act_a;  // {door_lock, motor, spin, fill, drain, soap, done}
    logic [3:0] st_b;
  } vec_t;
  vec_t vecs[25];

  always #5 clk = ~clk;

  wash_sequencer #(.CNT_W(16), .RINSE_CNT(1), .DET_TICKS(DET), .WASH_TICKS(WASH),
                   .RINSE_TICKS(RINSE), .SPIN_TICKS(SPIN), .FILL_TIMEOUT(FT)) dut_a (
    .clk(clk), .rst(rst), .start(start), .door_closed(door_closed), .pause(pause),
    .filled(filled), .drained(drained), .door_lock(lock_a), .motor_on(motor_a),
    .spin_on(spin_a), .fill_valve(fill_a), .drain_valve(drain_a), .soap_valve(soap_a),
    .done(done_a), .fault(fault_a), .state(state_a), .rinse_idx(ridx_a));

  wash_sequencer #(.CNT_W(16), .RINSE_CNT(0), .DET_TICKS(DET), .WASH_TICKS(WASH),
                   .RINSE_TICKS(RINSE), .SPIN_TICKS(SPIN), .FILL_TIMEOUT(FT)) dut_b (
    .clk(clk), .rst(rst), .start(start), .door_closed(door_closed), .pause(pause),
    .filled(filled), .drained(drained), .door_lock(lock_b), .motor_on(motor_b),
    .spin_on(spin_b), .fill_valve(fill_b), .drain_valve(drain_b), .soap_valve(soap_b),
    .done(done_b), .fault(fault_b), .state(state_b), .rinse_idx(ridx_b));

  assign obs_a = {state_a, ridx_a, lock_a, motor_a, spin_a, fill_a, drain_a, soap_a, done_a, fault_a};
  assign obs_b = {state_b, ridx_b, lock_b, motor_b, spin_b, fill_b, drain_b, soap_b, done_b, fault_b};

  function automatic int rinse_cnt(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  // Number of unpaused cycles a state lasts before its timed or watchdog exit.
  function automatic int duration(int st, bit rinse);
    case (st)
      2:       return DET;
      3:       return rinse ? RINSE : WASH;
      5:       return SPIN;
      default: return FT;
    endcase
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int prev;
      bit locked, pz, lk;
      prev = m_st[k];
      if (rst) begin
        m_st[k] = 0; m_el[k] = 0; m_idx[k] = 0; m_rinse[k] = 1'b0; m_out[k] = '0;
        continue;
      end
      locked = (prev >= 1 && prev <= 5);
      pz     = pause && locked;
      if (locked && !door_closed) begin
        m_st[k] = 7;
      end else if (!pz) begin
        case (prev)
          0: if (start && door_closed) begin m_st[k] = 1; m_idx[k] = 0; m_rinse[k] = 1'b0; end
          1: begin
            if (filled) m_st[k] = m_rinse[k] ? 3 : 2;
            else if (WD && m_el[k] + 1 == FT) m_st[k] = 7;
          end
          2, 3, 5: if (m_el[k] + 1 == duration(prev, m_rinse[k])) m_st[k] = (prev == 2) ? 3 : (prev == 3) ? 4 : 6;
          4: begin
            if (drained) begin
              if (!m_rinse[k]) begin
                m_rinse[k] = 1'b1;
                m_st[k] = (rinse_cnt(k) > 0) ? 1 : 5;
              end else begin
                m_idx[k]++;
                m_st[k] = (m_idx[k] < rinse_cnt(k)) ? 1 : 5;
              end
            end else if (WD && m_el[k] + 1 == FT) m_st[k] = 7;
          end
          6: if (!start) m_st[k] = 0;
          7: m_st[k] = 7;
          default: m_st[k] = 0;
        endcase
        m_el[k]++;
      end
      if (m_st[k] != prev) m_el[k] = 0;
      lk = (m_st[k] >= 1 && m_st[k] <= 5);
      m_out[k] = {4'(m_st[k]), 4'(m_idx[k]), lk,
                  (m_st[k] == 3) && !pz, (m_st[k] == 5) && !pz, (m_st[k] == 1) && !pz,
                  (m_st[k] == 4 || m_st[k] == 5) && !pz, (m_st[k] == 2) && !pz,
                  m_st[k] == 6, m_st[k] == 7};
    end
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: model consumes current inputs, then both DUTs are compared after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_output("model A", obs_a, m_out[0]);
    check_output("model B", obs_b, m_out[1]);
  endtask

  task automatic apply_stimulus(input logic [4:0] in);
    {start, door_closed, pause, filled, drained} = in;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(5'b01000);
    tick();
    tick();
    check_output("reset A", obs_a, 16'h0000);
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] target, input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && state_a != target; i++) tick();
    check_output(name, {12'd0, state_a}, {12'd0, target});
  endtask

  initial begin
    int occ;
    rst = 1'b1;
    apply_stimulus(5'b01000);

    vecs[0]  = '{5'b11000, 4'd1, 4'd0, 7'b1001000, 4'd1};
    vecs[1]  = '{5'b11000, 4'd1, 4'd0, 7'b1001000, 4'd1};
    vecs[2]  = '{5'b11010, 4'd2, 4'd0, 7'b1000010, 4'd2};
    vecs[3]  = '{5'b11000, 4'd2, 4'd0, 7'b1000010, 4'd2};
    vecs[4]  = '{5'b11000, 4'd3, 4'd0, 7'b1100000, 4'd3};
    vecs[5]  = '{5'b11000, 4'd3, 4'd0, 7'b1100000, 4'd3};
    vecs[6]  = '{5'b11000, 4'd3, 4'd0, 7'b1100000, 4'd3};
    vecs[7]  = '{5'b11000, 4'd3, 4'd0, 7'b1100000, 4'd3};
    vecs[8]  = '{5'b11000, 4'd4, 4'd0, 7'b1000100, 4'd4};
    vecs[9]  = '{5'b11000, 4'd4, 4'd0, 7'b1000100, 4'd4};
    vecs[10] = '{5'b11001, 4'd1, 4'd0, 7'b1001000, 4'd5};
    vecs[11] = '{5'b11000, 4'd1, 4'd0, 7'b1001000, 4'd5};
    vecs[12] = '{5'b11010, 4'd3, 4'd0, 7'b1100000, 4'd5};
    vecs[13] = '{5'b11000, 4'd3, 4'd0, 7'b1100000, 4'd5};
    vecs[14] = '{5'b11000, 4'd3, 4'd0, 7'b1100000, 4'd5};
    vecs[15] = '{5'b11000, 4'd4, 4'd0, 7'b1000100, 4'd6};
    vecs[16] = '{5'b11000, 4'd4, 4'd0, 7'b1000100, 4'd6};
    vecs[17] = '{5'b11001, 4'd5, 4'd1, 7'b1010100, 4'd6};
    vecs[18] = '{5'b11000, 4'd5, 4'd1, 7'b1010100, 4'd6};
    vecs[19] = '{5'b11000, 4'd5, 4'd1, 7'b1010100, 4'd6};
    vecs[20] = '{5'b11000, 4'd5, 4'd1, 7'b1010100, 4'd6};
    vecs[21] = '{5'b11000, 4'd5, 4'd1, 7'b1010100, 4'd6};
    vecs[22] = '{5'b11000, 4'd6, 4'd1, 7'b0000001, 4'd6};
    vecs[23] = '{5'b11000, 4'd6, 4'd1, 7'b0000001, 4'd6};
    vecs[24] = '{5'b01000, 4'd0, 4'd1, 7'b0000000, 4'd0};

    // Full program: sensors answer two cycles after each valve opens.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      apply_stimulus(vecs[i].in);
      tick();
      check_output($sformatf("vec%0d A", i), obs_a, {vecs[i].st_a, vecs[i].ri_a, vecs[i].act_a, 1'b0});
      check_output($sformatf("vec%0d B state", i), {12'd0, state_b}, {12'd0, vecs[i].st_b});
      check_output($sformatf("vec%0d B rinse_idx", i), {12'd0, ridx_b}, 16'd0);
    end

    // Pause for three cycles in the middle of the soap agitate.
    do_reset();
    apply_stimulus(5'b11010);
    wait_state(4'd3, 20, "reach AGITATE");
    occ = 1;
    tick();
    if (state_a == 4'd3) occ++;
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (state_a == 4'd3) occ++;
      check_output($sformatf("pause%0d motor", i), {15'd0, motor_a}, 16'd0);
      check_output($sformatf("pause%0d lock", i), {15'd0, lock_a}, 16'd1);
    end
    pause = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state_a == 4'd3) occ++;
      else break;
    end
    check_output("agitate occupancy", 16'(occ), 16'(WASH + 3));

    // Door opened during spin.
    drained = 1'b1;
    wait_state(4'd5, 60, "reach SPIN");
    door_closed = 1'b0;
    tick();
    check_output("door fault state", {12'd0, state_a}, 16'd7);
    check_output("door fault flags", {14'd0, fault_a, lock_a}, 16'd2);
    check_output("door fault actuators", {10'd0, motor_a, spin_a, fill_a, drain_a, soap_a, done_a}, 16'd0);
    apply_stimulus(5'b11000);
    for (int i = 0; i < 3; i++) tick();
    check_output("fault ignores start", {12'd0, state_a}, 16'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("fault cleared", {11'd0, fault_a, state_a}, 16'd0);

    // Reset pulse during detergent, then start with the door open.
    apply_stimulus(5'b11010);
    wait_state(4'd2, 20, "reach DETERGENT");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("rst in DETERGENT", obs_a, 16'h0000);
    apply_stimulus(5'b10000);
    for (int i = 0; i < 3; i++) tick();
    check_output("start door open", {12'd0, state_a}, 16'd0);

    // FILL with the drum never reporting full.
    do_reset();
    apply_stimulus(5'b11000);
    wait_state(4'd1, 5, "reach FILL");
`ifdef WASH_WATCHDOG_EN
    occ = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state_a == 4'd1) occ++;
      else break;
    end
    check_output("watchdog FILL cycles", 16'(occ), 16'(FT));
    check_output("watchdog fault", {12'd0, state_a}, 16'd7);
`else
    for (int i = 0; i < 100; i++) tick();
    check_output("no watchdog FILL", {12'd0, state_a}, 16'd1);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom % 64) == 0;
      start       = ($urandom % 3) == 0;
      door_closed = ($urandom % 48) != 0;
      pause       = ($urandom % 8) == 0;
      filled      = ($urandom % 4) == 0;
      drained     = ($urandom % 4) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
